// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-information and stage-control bundle shared between the five-stage datapath
// and the stall/flush/halt sequencer.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             mem_busy;
    logic [3:0]       ID_opcode;
    logic [3:0]       ID_rs_reg;
    logic [3:0]       ID_rt_reg;
    logic             ID_uses_rs;
    logic             ID_uses_rt;
    logic             ID_branch_taken;
    logic             ID_Hlt;
    logic [3:0]       EX_opcode;
    logic [3:0]       EX_rd_reg;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [3:0]       MEM_rd_reg;
    logic             MEM_MemRead;
    logic             PC_en;
    logic             IF_ID_en;
    logic             ID_EX_en;
    logic             EX_MEM_en;
    logic             MEM_WB_en;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output mem_busy, ID_opcode, ID_rs_reg, ID_rt_reg, ID_uses_rs, ID_uses_rt,
               ID_branch_taken, ID_Hlt, EX_opcode, EX_rd_reg, EX_MemRead, EX_RegWrite,
               MEM_rd_reg, MEM_MemRead,
        input  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush,
               halted, stall_cnt
    );

    modport slave (
        input  mem_busy, ID_opcode, ID_rs_reg, ID_rt_reg, ID_uses_rs, ID_uses_rt,
               ID_branch_taken, ID_Hlt, EX_opcode, EX_rd_reg, EX_MemRead, EX_RegWrite,
               MEM_rd_reg, MEM_MemRead,
        output PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush,
               halted, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the five-stage pipeline: hazard detection against ID,
// wrong-path squash on taken branches, post-HLT drain and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0] OP_B  = 4'b1100;
    localparam logic [3:0] OP_BR = 4'b1101;

    state_t           state, state_nxt;
    logic [1:0]       drain_cnt, drain_nxt;
    logic [CNT_W-1:0] stall_q;
    logic             rst_sync_p0, rst_sync_p1;
    logic             run_ok;
    logic             load_use, flag_haz, br_haz, hazard;
    logic             stall_evt;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic writes_flags(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    assign load_use = hz.EX_MemRead && (hz.EX_rd_reg != 4'd0) &&
                      ((hz.ID_uses_rs && (hz.EX_rd_reg == hz.ID_rs_reg)) ||
                       (hz.ID_uses_rt && (hz.EX_rd_reg == hz.ID_rt_reg)));
    assign flag_haz = ((hz.ID_opcode == OP_B) || (hz.ID_opcode == OP_BR)) &&
                      writes_flags(hz.EX_opcode);
    // BR needs its target register in ID; a LW keeps it unavailable through MEM.
    assign br_haz   = (hz.ID_opcode == OP_BR) && (hz.ID_rs_reg != 4'd0) &&
                      ((hz.EX_RegWrite && (hz.EX_rd_reg == hz.ID_rs_reg)) ||
                       (hz.MEM_MemRead && (hz.MEM_rd_reg == hz.ID_rs_reg)));
    assign hazard   = load_use || flag_haz || br_haz;
    assign run_ok   = rst_sync_p1;

    always_comb begin
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        stall_evt   = 1'b0;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (run_ok) begin
            case (state)
                RUN: begin
                    stall_evt = hz.mem_busy || hazard;
                    if (hz.mem_busy) begin
                        pc_en = 1'b0;
                    end else if (hazard) begin
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_en     = !hz.ID_Hlt || hz.ID_branch_taken;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        if_id_flush = hz.ID_branch_taken || hz.ID_Hlt;
                        if (!hz.ID_branch_taken && hz.ID_Hlt) begin
                            state_nxt = DRAIN;
                            drain_nxt = 2'd0;
                        end
                    end
                end
                DRAIN: begin
                    stall_evt = hz.mem_busy || hazard;
                    if (!hz.mem_busy) begin
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = 1'b1;
                        drain_nxt   = drain_cnt + 2'd1;
                        if (drain_cnt == 2'd2) state_nxt = HALTED;
                    end
                end
                default: state_nxt = HALTED;
            endcase
        end
    end

    // Reset release is re-timed to clk so every consumer leaves reset on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_p0 <= 1'b0;
            rst_sync_p1 <= 1'b0;
        end else begin
            rst_sync_p0 <= 1'b1;
            rst_sync_p1 <= rst_sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            stall_q   <= '0;
        end else if (run_ok) begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (stall_evt) stall_q <= sat_inc(stall_q);
        end
    end

    assign hz.PC_en       = pc_en;
    assign hz.IF_ID_en    = if_id_en;
    assign hz.ID_EX_en    = id_ex_en;
    assign hz.EX_MEM_en   = ex_mem_en;
    assign hz.MEM_WB_en   = mem_wb_en;
    assign hz.IF_ID_flush = if_id_flush;
    assign hz.ID_EX_flush = id_ex_flush;
    assign hz.halted      = (state == HALTED);
    assign hz.stall_cnt   = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle queues its expected stage
// controls and stall count, which are popped and compared mid-cycle.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W = 16;

    // {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush, halted}
    localparam logic [7:0] C_OFF  = 8'h00;
    localparam logic [7:0] C_RUN  = 8'hF8;
    localparam logic [7:0] C_HAZ  = 8'h3A;
    localparam logic [7:0] C_BRT  = 8'hFC;
    localparam logic [7:0] C_HLT  = 8'h7C;
    localparam logic [7:0] C_HALT = 8'h01;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NF  = 4'b0011;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_NF7 = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;

    typedef struct packed {
        logic       busy;
        logic [3:0] id_op, rs, rt;
        logic       urs, urt, bt, hlt;
        logic [3:0] ex_op, ex_rd;
        logic       ex_mr, ex_rw;
        logic [3:0] mem_rd;
        logic       mem_mr;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] ctl;
        logic       stall;
        logic       r;
    } row_t;

    typedef struct {
        logic [7:0]       ctl;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       ctl_obs;
    logic [CNT_W-1:0] model_cnt = '0;
    exp_t             sb[$];
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    assign ctl_obs = {hz.PC_en, hz.IF_ID_en, hz.ID_EX_en, hz.EX_MEM_en, hz.MEM_WB_en,
                      hz.IF_ID_flush, hz.ID_EX_flush, hz.halted};

    function automatic stim_t mk(input logic busy, input logic [3:0] id_op, rs, rt,
                                 input logic urs, urt, bt, hlt,
                                 input logic [3:0] ex_op, ex_rd, input logic ex_mr, ex_rw,
                                 input logic [3:0] mem_rd, input logic mem_mr);
        stim_t s;
        s.busy = busy; s.id_op = id_op; s.rs = rs; s.rt = rt;
        s.urs = urs; s.urt = urt; s.bt = bt; s.hlt = hlt;
        s.ex_op = ex_op; s.ex_rd = ex_rd; s.ex_mr = ex_mr; s.ex_rw = ex_rw;
        s.mem_rd = mem_rd; s.mem_mr = mem_mr;
        return s;
    endfunction

    function automatic stim_t nop();
        return mk(0, OP_NF, 0, 0, 0, 0, 0, 0, OP_NF, 0, 0, 0, 0, 0);
    endfunction

    function automatic row_t rw(input stim_t s, input logic [7:0] ctl, input logic stall,
                                input logic r);
        row_t t;
        t.s = s; t.ctl = ctl; t.stall = stall; t.r = r;
        return t;
    endfunction

    task automatic drive(input row_t t, input string name);
        exp_t e;
        rst                = t.r;
        hz.mem_busy        = t.s.busy;
        hz.ID_opcode       = t.s.id_op;
        hz.ID_rs_reg       = t.s.rs;
        hz.ID_rt_reg       = t.s.rt;
        hz.ID_uses_rs      = t.s.urs;
        hz.ID_uses_rt      = t.s.urt;
        hz.ID_branch_taken = t.s.bt;
        hz.ID_Hlt          = t.s.hlt;
        hz.EX_opcode       = t.s.ex_op;
        hz.EX_rd_reg       = t.s.ex_rd;
        hz.EX_MemRead      = t.s.ex_mr;
        hz.EX_RegWrite     = t.s.ex_rw;
        hz.MEM_rd_reg      = t.s.mem_rd;
        hz.MEM_MemRead     = t.s.mem_mr;
        if (!t.r) model_cnt = '0;
        e.ctl  = t.ctl;
        e.cnt  = model_cnt;
        e.name = name;
        sb.push_back(e);
        if (t.stall && (model_cnt != {CNT_W{1'b1}})) model_cnt = model_cnt + 1'b1;
    endtask

    task automatic apply_reset();
        drive(rw(nop(), C_OFF, 0, 0), "rst_hold");
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic test_reset();
        row_t t[$];
        exp_t e;
        stim_t haz = mk(0, OP_BR, 3, 0, 1, 0, 1, 0, OP_LW, 3, 1, 1, 0, 0);
        t.push_back(rw(haz,   C_OFF, 0, 0));
        t.push_back(rw(haz,   C_OFF, 0, 1));
        t.push_back(rw(haz,   C_OFF, 0, 1));
        t.push_back(rw(nop(), C_RUN, 0, 1));
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i], $sformatf("reset[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl got=%h want=%h", e.name, ctl_obs, e.ctl);
            end
            total++;
            if (hz.stall_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s stall_cnt got=%h want=%h", e.name, hz.stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        row_t t[$];
        exp_t e;
        t.push_back(rw(mk(0, OP_ADD, 3, 4, 1, 1, 0, 0, OP_LW, 3, 1, 1, 0, 0), C_HAZ, 1, 1));
        t.push_back(rw(mk(0, OP_ADD, 3, 4, 1, 1, 0, 0, OP_NF, 0, 0, 0, 3, 1), C_RUN, 0, 1));
        t.push_back(rw(mk(0, OP_ADD, 0, 0, 1, 1, 0, 0, OP_LW, 0, 1, 1, 0, 0), C_RUN, 0, 1));
        t.push_back(rw(mk(0, OP_SUB, 1, 7, 1, 1, 0, 0, OP_LW, 7, 1, 1, 0, 0), C_HAZ, 1, 1));
        t.push_back(rw(mk(0, OP_SUB, 1, 7, 1, 0, 0, 0, OP_LW, 7, 1, 1, 0, 0), C_RUN, 0, 1));
        t.push_back(rw(mk(0, OP_ADD, 3, 0, 1, 0, 0, 0, OP_NF, 3, 0, 1, 0, 0), C_RUN, 0, 1));
        t.push_back(rw(nop(), C_RUN, 0, 1));
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i], $sformatf("load_use[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl got=%h want=%h", e.name, ctl_obs, e.ctl);
            end
            total++;
            if (hz.stall_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s stall_cnt got=%h want=%h", e.name, hz.stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flag_branch();
        row_t t[$];
        exp_t e;
        t.push_back(rw(mk(0, OP_B,   0, 0, 0, 0, 1, 0, OP_SUB, 2, 0, 1, 0, 0), C_HAZ, 1, 1));
        t.push_back(rw(mk(0, OP_B,   0, 0, 0, 0, 1, 0, OP_NF,  0, 0, 0, 2, 0), C_BRT, 0, 1));
        t.push_back(rw(mk(0, OP_BR,  0, 0, 1, 0, 0, 0, OP_XOR, 9, 0, 1, 0, 0), C_HAZ, 1, 1));
        t.push_back(rw(mk(0, OP_B,   0, 0, 0, 0, 0, 0, OP_ROR, 1, 0, 1, 0, 0), C_HAZ, 1, 1));
        t.push_back(rw(mk(0, OP_B,   0, 0, 0, 0, 1, 0, OP_NF7, 1, 0, 1, 0, 0), C_BRT, 0, 1));
        t.push_back(rw(mk(0, OP_ADD, 0, 0, 0, 0, 0, 0, OP_SUB, 1, 0, 1, 0, 0), C_RUN, 0, 1));
        t.push_back(rw(mk(0, OP_B,   0, 0, 0, 0, 0, 0, OP_NF,  1, 0, 1, 0, 0), C_RUN, 0, 1));
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i], $sformatf("flag_branch[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl got=%h want=%h", e.name, ctl_obs, e.ctl);
            end
            total++;
            if (hz.stall_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s stall_cnt got=%h want=%h", e.name, hz.stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_br_reg();
        row_t t[$];
        exp_t e;
        t.push_back(rw(mk(0, OP_BR, 5, 0, 1, 0, 0, 0, OP_LW, 5, 1, 1, 0, 0), C_HAZ, 1, 1));
        t.push_back(rw(mk(0, OP_BR, 5, 0, 1, 0, 1, 0, OP_NF, 0, 0, 0, 5, 1), C_HAZ, 1, 1));
        t.push_back(rw(mk(0, OP_BR, 5, 0, 1, 0, 1, 0, OP_NF, 0, 0, 0, 0, 0), C_BRT, 0, 1));
        t.push_back(rw(mk(0, OP_BR, 6, 0, 1, 0, 0, 0, OP_NF, 6, 0, 1, 0, 0), C_HAZ, 1, 1));
        t.push_back(rw(mk(0, OP_BR, 6, 0, 1, 0, 1, 0, OP_NF, 0, 0, 0, 6, 0), C_BRT, 0, 1));
        t.push_back(rw(mk(0, OP_BR, 0, 0, 1, 0, 1, 0, OP_NF, 0, 0, 1, 0, 1), C_BRT, 0, 1));
        t.push_back(rw(mk(0, OP_B,  5, 0, 0, 0, 1, 0, OP_NF, 5, 0, 1, 0, 0), C_BRT, 0, 1));
        t.push_back(rw(mk(1, OP_BR, 5, 0, 1, 0, 1, 0, OP_LW, 5, 1, 1, 0, 0), C_OFF, 1, 1));
        t.push_back(rw(mk(0, OP_BR, 5, 0, 1, 0, 1, 0, OP_LW, 5, 1, 1, 0, 0), C_HAZ, 1, 1));
        t.push_back(rw(mk(1, OP_NF, 0, 0, 0, 0, 1, 0, OP_NF, 0, 0, 0, 0, 0), C_OFF, 1, 1));
        t.push_back(rw(nop(), C_RUN, 0, 1));
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i], $sformatf("br_reg[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl got=%h want=%h", e.name, ctl_obs, e.ctl);
            end
            total++;
            if (hz.stall_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s stall_cnt got=%h want=%h", e.name, hz.stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        row_t t[$];
        exp_t e;
        stim_t hlt  = mk(0, OP_NF, 0, 0, 0, 0, 0, 1, OP_NF, 0, 0, 0, 0, 0);
        stim_t busy = mk(1, OP_NF, 0, 0, 0, 0, 0, 0, OP_NF, 0, 0, 0, 0, 0);
        stim_t noise = mk(1, OP_BR, 5, 0, 1, 0, 1, 0, OP_LW, 5, 1, 1, 0, 0);
        t.push_back(rw(hlt,   C_HLT,  0, 1));
        t.push_back(rw(nop(), C_HLT,  0, 1));
        t.push_back(rw(busy,  C_OFF,  1, 1));
        t.push_back(rw(nop(), C_HLT,  0, 1));
        t.push_back(rw(nop(), C_HLT,  0, 1));
        t.push_back(rw(nop(), C_HALT, 0, 1));
        t.push_back(rw(noise, C_HALT, 0, 1));
        t.push_back(rw(noise, C_OFF,  0, 0));
        t.push_back(rw(nop(), C_OFF,  0, 1));
        t.push_back(rw(nop(), C_OFF,  0, 1));
        t.push_back(rw(nop(), C_RUN,  0, 1));
        t.push_back(rw(hlt,   C_HLT,  0, 1));
        t.push_back(rw(nop(), C_HLT,  0, 1));
        t.push_back(rw(nop(), C_OFF,  0, 0));
        t.push_back(rw(nop(), C_OFF,  0, 1));
        t.push_back(rw(nop(), C_OFF,  0, 1));
        t.push_back(rw(nop(), C_RUN,  0, 1));
        t.push_back(rw(nop(), C_RUN,  0, 1));
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i], $sformatf("halt[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl got=%h want=%h", e.name, ctl_obs, e.ctl);
            end
            total++;
            if (hz.stall_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s stall_cnt got=%h want=%h", e.name, hz.stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate_reset();
        row_t t[$];
        exp_t e;
        stim_t lu = mk(0, OP_ADD, 3, 0, 1, 0, 0, 0, OP_LW, 3, 1, 1, 0, 0);
        stim_t busy = mk(1, OP_NF, 0, 0, 0, 0, 0, 0, OP_NF, 0, 0, 0, 0, 0);
        apply_reset();
        model_cnt = '0;
        hz.mem_busy = 1'b1;
        for (int i = 0; i < 16'hFFFE; i++) @(posedge clk);
        #1;
        model_cnt = 16'hFFFE;
        t.push_back(rw(lu,    C_HAZ, 1, 1));
        t.push_back(rw(lu,    C_HAZ, 1, 1));
        t.push_back(rw(busy,  C_OFF, 1, 1));
        t.push_back(rw(lu,    C_HAZ, 1, 1));
        t.push_back(rw(lu,    C_OFF, 0, 0));
        t.push_back(rw(lu,    C_OFF, 0, 1));
        t.push_back(rw(lu,    C_OFF, 0, 1));
        t.push_back(rw(nop(), C_RUN, 0, 1));
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i], $sformatf("saturate[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl got=%h want=%h", e.name, ctl_obs, e.ctl);
            end
            total++;
            if (hz.stall_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s stall_cnt got=%h want=%h", e.name, hz.stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_flag_branch();
        test_br_reg();
        test_halt();
        test_saturate_reset();
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
